fir_out_decim: RTL and testbench

Output-side companion to the 11-tap symmetric FIR. It consumes the filter's 33-bit full-precision output, which advances on each `ce` strobe. It discards outputs until the filter pipeline has filled, then keeps every DECIM-th sample. Each kept sample is rounded and saturated to OUT_W bits and delivered through a 2-entry valid/ready FIFO to the downstream consumer (DAC formatter / serializer).

---
 rtl/fir_out_decim.sv | 180 ++++++++++++++++++
 tb/tb_fir_out_decim.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_decim.sv
// fir_out_decim: FIR output priming, decimation, round/saturate and 2-deep
// valid/ready output FIFO.
//
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   sync_clr       synchronous clear (ovf is kept)
//   ce             sample strobe shared with the FIR
//   y_in           signed full-precision filter output, valid the cycle after ce
//   dout           signed rounded/saturated head sample
//   dout_valid     dout holds a sample
//   dout_ready     consumer accepts dout
//   sat            pulse: the sample just written to the FIFO was clipped
//   ovf            sticky: a kept sample was lost to a full FIFO (rst_n only)
//
// Build option: define FIR_OUT_CONV_ROUND_EN for round-half-to-even;
// the default build rounds half up.
module fir_out_decim #(
    parameter int IN_W     = 33,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 16,
    parameter int DECIM    = 2,
    parameter int PIPE_LAT = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync_clr,
    input  logic                    ce,
    input  logic signed [IN_W-1:0]  y_in,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    sat,
    output logic                    ovf
);

    localparam int PW = $clog2(PIPE_LAT + 2);
    localparam int DW = $clog2(DECIM + 1);

    localparam logic signed [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

    // strobe delay, priming and decimation state
    logic          ce_d;
    logic [PW-1:0] prime;
    logic [DW-1:0] phase;
    logic          primed;
    logic          keep;

    // rounding datapath
    logic signed [IN_W:0]    q;
    logic signed [IN_W:0]    r;
    logic                    up;
    logic                    ovr;
    logic signed [OUT_W-1:0] rs;

    // stage 1
    logic                    s1_v;
    logic signed [OUT_W-1:0] s1_d;
    logic                    s1_sat;

    // FIFO
    logic signed [OUT_W-1:0] tail;
    logic [1:0]              cnt;
    logic                    pop;
    logic                    full;
    logic                    push;

    // prime saturates at PIPE_LAT, so equality means "pipeline filled"
    assign primed = (prime == PW'(PIPE_LAT));
    assign keep   = ce_d && primed && (phase == '0);

    // floor quotient, computed one bit wider so +1 cannot overflow
    assign q = $signed({y_in[IN_W-1], y_in}) >>> SHIFT;

`ifdef FIR_OUT_CONV_ROUND_EN
    localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);

    // exact half with an even floor stays put; otherwise round to nearest
    assign up = y_in[SHIFT-1] &&
                !((y_in[SHIFT-1:0] == HALF) && !q[0]);
`else
    // remainder >= half rounds up
    assign up = y_in[SHIFT-1];
`endif

    assign r = q + {{IN_W{1'b0}}, up};

    // out of range when the bits above the output sign are not all equal
    assign ovr = !((&r[IN_W:OUT_W-1]) || !(|r[IN_W:OUT_W-1]));

    always_comb begin
        rs = r[OUT_W-1:0];
        if (ovr) begin
            rs = r[IN_W] ? MINV : MAXV;
        end
    end

    assign dout_valid = (cnt != 2'd0);
    assign full       = (cnt == 2'd2);
    assign pop        = dout_valid && dout_ready;
    // a full FIFO still takes a push when the head leaves the same cycle
    assign push       = s1_v && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_d   <= 1'b0;
            prime  <= '0;
            phase  <= '0;
            s1_v   <= 1'b0;
            s1_d   <= '0;
            s1_sat <= 1'b0;
            dout   <= '0;
            tail   <= '0;
            cnt    <= 2'd0;
            sat    <= 1'b0;
            ovf    <= 1'b0;
        end else if (sync_clr) begin
            ce_d   <= 1'b0;
            prime  <= '0;
            phase  <= '0;
            s1_v   <= 1'b0;
            s1_d   <= '0;
            s1_sat <= 1'b0;
            dout   <= '0;
            tail   <= '0;
            cnt    <= 2'd0;
            sat    <= 1'b0;
        end else begin
            ce_d <= ce;

            if (ce_d) begin
                if (!primed) begin
                    prime <= prime + 1'b1;
                end else if (phase == DW'(DECIM - 1)) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
            end

            s1_v <= keep;
            if (keep) begin
                s1_d   <= rs;
                s1_sat <= ovr;
            end

            sat <= push && s1_sat;

            if (s1_v && full && !pop) begin
                ovf <= 1'b1;
            end

            unique case (1'b1)
                push && !pop: begin
                    if (cnt == 2'd0) begin
                        dout <= s1_d;
                    end else begin
                        tail <= s1_d;
                    end
                    cnt <= cnt + 2'd1;
                end
                !push && pop: begin
                    dout <= tail;
                    cnt  <= cnt - 2'd1;
                end
                push && pop: begin
                    if (cnt == 2'd1) begin
                        dout <= s1_d;
                    end else begin
                        dout <= tail;
                        tail <= s1_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_out_decim.sv
// tb_fir_out_decim: randomized self-checking bench for fir_out_decim
// against an arithmetic reference of priming, decimation and rounding.
module tb_fir_out_decim;

    localparam int IN_W     = 33;
    localparam int OUT_W    = 16;
    localparam int SHIFT    = 16;
    localparam int DECIM    = 2;
    localparam int PIPE_LAT = 5;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    sync_clr = 1'b0;
    logic                    ce = 1'b0;
    logic signed [IN_W-1:0]  y_in = '0;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready = 1'b0;
    logic                    sat;
    logic                    ovf;

    int errs = 0;
    int checks = 0;
    int nstr = 0;
    logic signed [IN_W-1:0] pend = '0;

    always #5 clk = ~clk;

    fir_out_decim #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .DECIM(DECIM), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .ce(ce),
        .y_in(y_in), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .sat(sat), .ovf(ovf)
    );

    // ---------------- reference model ----------------
    function automatic bit keep_n(int n);
        return (n >= PIPE_LAT) && (((n - PIPE_LAT) % DECIM) == 0);
    endfunction

    function automatic bit take();
        bit k;
        k = keep_n(nstr);
        nstr++;
        return k;
    endfunction

    function automatic longint fdiv(longint a, longint b);
        longint qq;
        qq = a / b;
        if ((a % b) != 0 && a < 0) qq = qq - 1;
        return qq;
    endfunction

    function automatic longint round_ref(longint y);
        longint d, h, f, rem;
        d = longint'(1) << SHIFT;
        h = d / 2;
`ifdef FIR_OUT_CONV_ROUND_EN
        f = fdiv(y, d);
        rem = y - f * d;
        if (rem > h || (rem == h && (f % 2) != 0)) f = f + 1;
        return f;
`else
        f = fdiv(y + h, d);
        rem = 0;
        return f + rem;
`endif
    endfunction

    function automatic logic signed [OUT_W-1:0] exp_out(logic signed [IN_W-1:0] y);
        longint v, hi, lo;
        v = round_ref(longint'(y));
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return OUT_W'(v);
    endfunction

    function automatic bit exp_sat(logic signed [IN_W-1:0] y);
        longint v;
        v = round_ref(longint'(y));
        return (v > (longint'(1) << (OUT_W - 1)) - 1) ||
               (v < -(longint'(1) << (OUT_W - 1)));
    endfunction

    function automatic logic signed [IN_W-1:0] rnd_y();
        longint s;
        case ($urandom_range(0, 2))
            0: return IN_W'($signed($urandom));
            1: return {1'($urandom), 32'($urandom)};
            default: begin
                s = longint'($urandom_range(0, 2000)) - 1000;
                return IN_W'(s * 65536 + 32768);
            end
        endcase
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: inputs change just after the rising edge, the
    // previous strobe's value appears on y_in, and the task returns at the
    // falling edge where outputs are sampled.
    task automatic step(input bit c, input logic signed [IN_W-1:0] y,
                        input bit rdy, input bit clr);
        @(posedge clk);
        #1;
        y_in = pend;
        ce = c;
        dout_ready = rdy;
        sync_clr = clr;
        if (c) pend = y;
        @(negedge clk);
    endtask

    // Sends discarded strobes until the next one will be kept.
    task automatic align(input bit rdy);
        while (!keep_n(nstr)) begin
            void'(take());
            step(1'b1, IN_W'(0), rdy, 1'b0);
            repeat (3) step(1'b0, IN_W'(0), rdy, 1'b0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nstr = 0;
        pend = '0;
        @(negedge clk);
        checks++;
        if (dout !== '0) begin
            errs++; $display("FAIL reset_dout got=%0d want=0", dout);
        end
        checks++;
        if (dout_valid !== 1'b0) begin
            errs++; $display("FAIL reset_valid got=%b want=0", dout_valid);
        end
        checks++;
        if (sat !== 1'b0) begin
            errs++; $display("FAIL reset_sat got=%b want=0", sat);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errs++; $display("FAIL reset_ovf got=%b want=0", ovf);
        end
    endtask

    task automatic test_prime_decim();
        for (int k = 1; k <= 12; k++) begin
            bit kp;
            logic signed [IN_W-1:0] y;
            y = IN_W'(longint'(k) * 65536);
            kp = take();
            step(1'b1, y, 1'b1, 1'b0);
            for (int c = 1; c <= 3; c++) begin
                step(1'b0, IN_W'(0), 1'b1, 1'b0);
                checks++;
                if (dout_valid !== ((c == 3) ? kp : 1'b0)) begin
                    errs++;
                    $display("FAIL prime_valid k=%0d cyc=%0d got=%b want=%b",
                             k, c, dout_valid, (c == 3) ? kp : 1'b0);
                end
            end
            if (kp) begin
                checks++;
                if (dout !== OUT_W'(k)) begin
                    errs++;
                    $display("FAIL prime_dout k=%0d got=%0d want=%0d", k, dout, k);
                end
            end
        end
    endtask

    task automatic test_rounding();
        longint tab[6];
        tab = '{98304, -98304, 163840, 32768, -32768, -163840};
        for (int i = 0; i < 16; i++) begin
            logic signed [IN_W-1:0] y;
            logic signed [OUT_W-1:0] e;
            y = (i < 6) ? IN_W'(tab[i]) : rnd_y();
            e = exp_out(y);
            align(1'b1);
            void'(take());
            step(1'b1, y, 1'b1, 1'b0);
            repeat (3) step(1'b0, IN_W'(0), 1'b1, 1'b0);
            checks++;
            if (dout_valid !== 1'b1 || dout !== e) begin
                errs++;
                $display("FAIL round y=%0d got=%0d/v%b want=%0d",
                         y, dout, dout_valid, e);
            end
        end
    endtask

    task automatic test_saturation();
        longint tab[5];
        tab[0] = longint'(1) << 31;
        tab[1] = -(longint'(1) << 32);
        tab[2] = longint'(32767) * 65536;
        tab[3] = longint'(-32768) * 65536;
        tab[4] = longint'(32767) * 65536 + 32768;
        for (int i = 0; i < 12; i++) begin
            logic signed [IN_W-1:0] y;
            y = (i < 5) ? IN_W'(tab[i]) : {1'($urandom), 32'($urandom)};
            align(1'b1);
            void'(take());
            step(1'b1, y, 1'b1, 1'b0);
            repeat (3) step(1'b0, IN_W'(0), 1'b1, 1'b0);
            checks++;
            if (dout_valid !== 1'b1 || dout !== exp_out(y)) begin
                errs++;
                $display("FAIL sat_dout y=%0d got=%0d want=%0d",
                         y, dout, exp_out(y));
            end
            checks++;
            if (sat !== exp_sat(y)) begin
                errs++;
                $display("FAIL sat_flag y=%0d got=%b want=%b", y, sat, exp_sat(y));
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 16;
        logic signed [IN_W-1:0] ys[N];
        bit kps[N];
        for (int t = 0; t < N; t++) ys[t] = rnd_y();
        for (int t = 0; t < N + 4; t++) begin
            int idx;
            if (t < N) begin
                kps[t] = take();
                step(1'b1, ys[t], 1'b1, 1'b0);
            end else begin
                step(1'b0, IN_W'(0), 1'b1, 1'b0);
            end
            idx = t - 3;
            checks++;
            if (idx >= 0 && idx < N && kps[idx]) begin
                if (dout_valid !== 1'b1 || dout !== exp_out(ys[idx])) begin
                    errs++;
                    $display("FAIL b2b t=%0d got=%0d/v%b want=%0d",
                             t, dout, dout_valid, exp_out(ys[idx]));
                end
            end else if (dout_valid !== 1'b0) begin
                errs++;
                $display("FAIL b2b_idle t=%0d got=v%b want=v0", t, dout_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [IN_W-1:0] v[3];
        logic signed [OUT_W-1:0] ea;
        logic signed [OUT_W-1:0] eb;
        for (int i = 0; i < 3; i++) v[i] = IN_W'($signed(16'($urandom)));
        ea = exp_out(v[0]);
        eb = exp_out(v[1]);
        for (int i = 0; i < 3; i++) begin
            align(1'b0);
            void'(take());
            step(1'b1, v[i], 1'b0, 1'b0);
            repeat (3) step(1'b0, IN_W'(0), 1'b0, 1'b0);
            if (i == 1) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errs++; $display("FAIL bp_ovf_early got=%b want=0", ovf);
                end
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errs++; $display("FAIL bp_ovf got=%b want=1", ovf);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, IN_W'(0), 1'b0, 1'b0);
            checks++;
            if (dout_valid !== 1'b1 || dout !== ea) begin
                errs++;
                $display("FAIL bp_hold c=%0d got=%0d/v%b want=%0d",
                         c, dout, dout_valid, ea);
            end
        end
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== ea) begin
            errs++; $display("FAIL bp_a got=%0d want=%0d", dout, ea);
        end
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== eb) begin
            errs++; $display("FAIL bp_b got=%0d want=%0d", dout, eb);
        end
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || ovf !== 1'b1) begin
            errs++;
            $display("FAIL bp_end got=v%b ovf%b want=v0 ovf1", dout_valid, ovf);
        end
    endtask

    task automatic test_clear();
        logic signed [IN_W-1:0] y;
        align(1'b0);
        void'(take());
        step(1'b1, IN_W'(65536 * 7), 1'b0, 1'b0);
        repeat (3) step(1'b0, IN_W'(0), 1'b0, 1'b0);
        align(1'b0);
        void'(take());
        step(1'b1, IN_W'(65536 * 9), 1'b0, 1'b0);
        step(1'b0, IN_W'(0), 1'b0, 1'b0);
        step(1'b0, IN_W'(0), 1'b0, 1'b1);
        nstr = 0;
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || dout !== '0 || ovf !== 1'b1) begin
            errs++;
            $display("FAIL clr_state got=v%b d%0d ovf%b want=v0 d0 ovf1",
                     dout_valid, dout, ovf);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, IN_W'(0), 1'b1, 1'b0);
            checks++;
            if (dout_valid !== 1'b0) begin
                errs++; $display("FAIL clr_flush c=%0d got=v%b want=v0", c, dout_valid);
            end
        end
        for (int k = 0; k <= PIPE_LAT; k++) begin
            bit kp;
            y = IN_W'($signed(20'($urandom)));
            kp = take();
            step(1'b1, y, 1'b1, 1'b0);
            repeat (3) step(1'b0, IN_W'(0), 1'b1, 1'b0);
            checks++;
            if (dout_valid !== kp || (kp && dout !== exp_out(y))) begin
                errs++;
                $display("FAIL clr_reprime k=%0d got=%0d/v%b want=v%b %0d",
                         k, dout, dout_valid, kp, exp_out(y));
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (ovf !== 1'b0 || dout_valid !== 1'b0) begin
            errs++;
            $display("FAIL async_rst got=ovf%b v%b want=ovf0 v0", ovf, dout_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nstr = 0;
        pend = '0;
    endtask

    task automatic test_full_pushpop();
        logic signed [IN_W-1:0] v[3];
        for (int i = 0; i < 3; i++) v[i] = IN_W'($signed(18'($urandom)));
        for (int i = 0; i < 2; i++) begin
            align(1'b0);
            void'(take());
            step(1'b1, v[i], 1'b0, 1'b0);
            repeat (3) step(1'b0, IN_W'(0), 1'b0, 1'b0);
        end
        align(1'b0);
        void'(take());
        step(1'b1, v[2], 1'b0, 1'b0);
        step(1'b0, IN_W'(0), 1'b0, 1'b0);
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        step(1'b0, IN_W'(0), 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== exp_out(v[1]) || ovf !== 1'b0) begin
            errs++;
            $display("FAIL pp_head got=%0d/v%b ovf%b want=%0d ovf0",
                     dout, dout_valid, ovf, exp_out(v[1]));
        end
        step(1'b0, IN_W'(0), 1'b0, 1'b0);
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== exp_out(v[1])) begin
            errs++; $display("FAIL pp_b got=%0d want=%0d", dout, exp_out(v[1]));
        end
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== exp_out(v[2])) begin
            errs++; $display("FAIL pp_c got=%0d want=%0d", dout, exp_out(v[2]));
        end
        step(1'b0, IN_W'(0), 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || ovf !== 1'b0) begin
            errs++;
            $display("FAIL pp_end got=v%b ovf%b want=v0 ovf0", dout_valid, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_prime_decim();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_full_pushpop();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
